// File: rtl/keypad_pkg.sv
// Shared types and default constants for the keypad entry encoder.
//   kp_state_e       : entry FSM state encoding
//   DEF_*            : default parameter values used by the encoder top
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_LOAD         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } kp_state_e;

    localparam int DEF_NUM_KEYS     = 10;
    localparam int DEF_DIGIT_W      = 4;
    localparam int DEF_NUM_DIGITS   = 4;
    localparam int DEF_DEBOUNCE_CYC = 4;
    localparam int DEF_DIV          = 100;

endpackage

// File: rtl/keypad_entry_encoder_tick_divider.sv
// Free-running clock divider producing a one-cycle tick every DIV cycles.
//   clk  : system clock (rising edge)
//   rst  : synchronous active-high reset, clears counter and tick
//   tick : registered, high for one cycle while the counter holds DIV-1
module tick_divider #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (cnt_q == W'(DIV - 1)) begin
            cnt_d = '0;
        end
    end

    // The tick is registered from the next counter value so it is high in
    // exactly the cycle where the counter reads DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tick  <= (cnt_d == W'(DIV - 1));
        end
    end

endmodule

// File: rtl/keypad_entry_encoder.sv
// Debounced one-hot keypad encoder with a shifting digit entry buffer.
//   clk, rst   : system clock, synchronous active-high reset
//   enablen    : active-low enable for accepting new keys
//   keypad     : one-hot key lines, bit k = key k
//   clear      : synchronous clear of the entry buffer (wins over a load)
//   digit      : code of the last accepted key
//   load       : one-cycle pulse per accepted key
//   pgt_1hz    : one-cycle tick every DIV clocks
//   entry      : packed entered digits, newest digit in the LSB field
//   count      : number of valid digits in entry
//   full       : count == NUM_DIGITS
//   multi_err  : one-cycle pulse when more than one key is seen while scanning
//   dbg_state  : current FSM state
//
// Handshake: load is a single-cycle strobe; digit/entry/count/full are
// updated on the same edge that raises load and stay stable afterwards.
module keypad_entry_encoder
    import keypad_pkg::*;
#(
    parameter int NUM_KEYS     = DEF_NUM_KEYS,
    parameter int DIGIT_W      = DEF_DIGIT_W,
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int DIV          = DEF_DIV
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enablen,
    input  logic [NUM_KEYS-1:0]             keypad,
    input  logic                            clear,
    output logic [DIGIT_W-1:0]              digit,
    output logic                            load,
    output logic                            pgt_1hz,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   entry,
    output logic [$clog2(NUM_DIGITS+1)-1:0] count,
    output logic                            full,
    output logic                            multi_err,
    output kp_state_e                       dbg_state
);

    localparam int ENTRY_W = NUM_DIGITS * DIGIT_W;
    localparam int CNT_W   = $clog2(NUM_DIGITS + 1);
    localparam int DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    kp_state_e          state_q, state_d;
    logic [DIGIT_W-1:0] key_q, key_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;

    logic               key_any;
    logic               key_multi;
    logic               key_single;
    logic [DIGIT_W-1:0] key_code;

    // Clearing the lowest set bit leaves something behind only when two or
    // more lines are active.
    assign key_any    = |keypad;
    assign key_multi  = |(keypad & (keypad - NUM_KEYS'(1)));
    assign key_single = key_any & ~key_multi;

    always_comb begin
        key_code = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (keypad[k]) begin
                key_code = DIGIT_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            key_q    <= '0;
            db_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        db_cnt_d = db_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!enablen && key_single) begin
                    key_d    = key_code;
                    db_cnt_d = '0;
                    state_d  = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                // Any disturbance (release, change, extra key, disable)
                // drops back to IDLE without accepting anything.
                if (!enablen && key_single && (key_code == key_q)) begin
                    if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
                        state_d = ST_LOAD;
                    end else begin
                        db_cnt_d = db_cnt_q + DB_W'(1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                // enablen is deliberately ignored here; only a full release
                // re-arms the scanner.
                if (!key_any) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dbg_state = state_q;

    // Output register stage. The LOAD state acts on this edge, so load and
    // the buffer update appear together one cycle after LOAD is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit     <= '0;
            load      <= 1'b0;
            entry     <= '0;
            count     <= '0;
            full      <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            load      <= (state_q == ST_LOAD);
            multi_err <= ((state_q == ST_IDLE) || (state_q == ST_DEBOUNCE)) && key_multi;
            if (state_q == ST_LOAD) begin
                digit <= key_q;
            end
            if (clear) begin
                entry <= '0;
                count <= '0;
                full  <= 1'b0;
            end else if ((state_q == ST_LOAD) && !full) begin
                entry <= (entry << DIGIT_W) | ENTRY_W'(key_q);
                count <= count + CNT_W'(1);
                full  <= (count == CNT_W'(NUM_DIGITS - 1));
            end
        end
    end

    tick_divider #(
        .DIV (DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .tick (pgt_1hz)
    );

endmodule

// File: tb/tb_keypad_entry_encoder.sv
// Self-checking bench for keypad_entry_encoder: default configuration plus a
// 16-key, DIV=4 instance for the wide-key and fast-divider cases.
module tb_keypad_entry_encoder;
    import keypad_pkg::*;

    localparam int NK = 10;
    localparam int DW = 4;
    localparam int ND = 4;
    localparam int DB = 4;
    localparam int EW = ND * DW;
    localparam int CW = $clog2(ND + 1);
    localparam int SW = DW + EW + CW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          enablen = 1'b1;
    logic          clear   = 1'b0;
    logic [NK-1:0] keypad  = '0;
    logic [DW-1:0] digit;
    logic          load, pgt_1hz, full, merr;
    logic [EW-1:0] entry;
    logic [CW-1:0] count;
    kp_state_e     dbg_state;

    logic [15:0]   kp2 = '0;
    logic [3:0]    digit2;
    logic          load2, pgt2, full2, merr2;
    logic [15:0]   entry2;
    logic [2:0]    count2;
    kp_state_e     dbg2;

    keypad_entry_encoder dut (
        .clk(clk), .rst(rst), .enablen(enablen), .keypad(keypad), .clear(clear),
        .digit(digit), .load(load), .pgt_1hz(pgt_1hz), .entry(entry), .count(count),
        .full(full), .multi_err(merr), .dbg_state(dbg_state)
    );

    keypad_entry_encoder #(.NUM_KEYS(16), .DIV(4)) dut2 (
        .clk(clk), .rst(rst), .enablen(1'b0), .keypad(kp2), .clear(1'b0),
        .digit(digit2), .load(load2), .pgt_1hz(pgt2), .entry(entry2), .count(count2),
        .full(full2), .multi_err(merr2), .dbg_state(dbg2)
    );

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [SW-1:0] exp_q[$];
    logic [EW-1:0] m_entry = '0;
    int            m_count = 0;
    int            cyc = 0;
    int            load_cyc = -1;
    int            n_multi = 0;
    int            last_t = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_accept(input int k, input bit clr);
        if (clr) begin
            m_entry = '0;
            m_count = 0;
        end else if (m_count < ND) begin
            m_entry = {m_entry[EW-DW-1:0], DW'(k)};
            m_count++;
        end
        exp_q.push_back({DW'(k), m_entry, CW'(m_count), (m_count == ND)});
    endtask

    always @(negedge clk) begin
        logic [SW-1:0] e;
        if (merr) n_multi++;
        if (load) begin
            load_cyc = cyc;
            check("load_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("digit", digit, e[SW-1 -: DW]);
                check("entry", entry, e[1+CW +: EW]);
                check("count", count, e[1 +: CW]);
                check("full", full, e[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // hold = number of rising edges that sample the key.
    task automatic press(input int k, input int hold, input bit clr_in_load);
        @(negedge clk);
        keypad = NK'(1) << k;
        last_t = cyc + 1;
        if (hold >= DB + 1) push_accept(k, clr_in_load);
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (clr_in_load && i == DB + 1) clear = 1'b1;
            if (i == DB + 2) clear = 1'b0;
        end
        keypad = '0;
        clear  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_digit"}, digit, 0);
        check({tag, "_load"}, load, 0);
        check({tag, "_pgt"}, pgt_1hz, 0);
        check({tag, "_entry"}, entry, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_merr"}, merr, 0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int nm;
        int k;
        bit seen;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        enablen = 1'b0;

        // single key 3 held 10 cycles, latency t+5
        press(3, 10, 1'b0);
        check("latency", load_cyc - last_t, DB + 1);

        // clear the buffer
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check("clear_entry", entry, 0);
        check("clear_count", count, 0);
        m_entry = '0;
        m_count = 0;

        // keys 1..5: fill, then overflow discarded
        for (int i = 1; i <= 5; i++) press(i, 8, 1'b0);
        check("full_after_5", full, 1);
        check("entry_after_5", entry, 16'h1234);

        // clear coincident with LOAD
        press(6, 8, 1'b1);
        check("clr_load_full", full, 0);

        // two keys at once: multi_err each IDLE cycle, no load
        nm = n_multi;
        @(negedge clk); keypad = NK'(3);
        repeat (3) @(negedge clk);
        keypad = '0;
        repeat (2) @(negedge clk);
        check("multi_pulses", n_multi - nm, 3);

        // short press: no load
        press(7, 2, 1'b0);

        // long hold: exactly one load
        press(9, 50, 1'b0);

        // enablen pulse during DEBOUNCE restarts debounce; key released early
        @(negedge clk); keypad = NK'(1) << 2;
        @(negedge clk);
        @(negedge clk); enablen = 1'b1;
        @(negedge clk); enablen = 1'b0;
        @(negedge clk);
        @(negedge clk); keypad = '0;
        repeat (3) @(negedge clk);

        // random accepted keys
        repeat (3) begin
            k = $urandom_range(0, NK - 1);
            press(k, $urandom_range(6, 12), 1'b0);
        end
        check("rand_count", count, m_count);

        // reset in the middle of DEBOUNCE; key stays held briefly afterwards
        @(negedge clk); keypad = NK'(1) << 5;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_db");
        m_entry = '0;
        m_count = 0;

        // divider phase from the reset edge; both instances
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 2) keypad = '0;
            check("pgt_1hz", pgt_1hz, 32'((i % 100) == 99));
            check("pgt_div4", pgt2, 32'((i % 4) == 3));
        end

        // 16-key instance, key 15
        @(negedge clk); kp2 = 16'h8000;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (load2) seen = 1'b1;
        end
        check("dut2_load_seen", seen, 1);
        check("dut2_digit", digit2, 4'hF);
        check("dut2_entry", entry2, 16'h000F);
        check("dut2_count", count2, 1);
        kp2 = '0;
        repeat (3) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
